// File: rtl/rx_assemble.sv
// rx_assemble
//   Collects 16 consecutive bytes from the UART receiver into one 128-bit word,
//   with the first byte in [127:120] and the last in [7:0]. It then hands the
//   word to the downstream buffer that feeds the AES core.
//   If the line goes quiet in the middle of a frame, the partial frame is
//   discarded. Bytes that arrive while a finished word is still waiting to be
//   written are dropped and flagged.
//
// Ports
//   clk          : system clock; all logic runs on the rising edge
//   reset        : synchronous, active-low
//   rx_data      : received byte, valid while rx_done is high
//   rx_done      : single-cycle byte strobe from the UART receiver
//   buffer_full  : the downstream buffer cannot accept a write this cycle
//   buffer_write : one-cycle write strobe to the downstream buffer
//   d_out        : assembled word, valid while buffer_write is high
//   busy         : a frame is partially or fully assembled and not yet written
//   overrun      : one-cycle pulse when a byte is dropped while a word waits
//   timeout      : one-cycle pulse when a partial frame is discarded
//
// Parameters
//   TIMEOUT_CYCLES : idle cycles allowed between bytes of a frame (>= 2)

module rx_assemble #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_done,
  input  logic         buffer_full,
  output logic         buffer_write,
  output logic [127:0] d_out,
  output logic         busy,
  output logic         overrun,
  output logic         timeout
);

  // The counter only has to reach TIMEOUT_CYCLES-1.
  localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2
  } state_t;

  state_t            state_q;
  logic [3:0]        ctr_q;
  logic [TCNT_W-1:0] tcnt_q;
  logic [127:0]      d_out_q;
  logic              buffer_write_q;
  logic              busy_q;
  logic              overrun_q;
  logic              timeout_q;

  // The word shifts left by one byte on every capture. After 16 captures,
  // the oldest byte has reached the top lane.
  logic [127:0] d_out_d;
  assign d_out_d = {d_out_q[119:0], rx_data};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      ctr_q          <= 4'd0;
      tcnt_q         <= '0;
      d_out_q        <= '0;
      buffer_write_q <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      // All event outputs are single-cycle pulses by default.
      buffer_write_q <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_q      <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (rx_done) begin
            d_out_q <= d_out_d;
            ctr_q   <= ctr_q + 4'd1;
            tcnt_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (rx_done) begin
            // A byte arriving on the expiry edge still wins over the timeout.
            d_out_q <= d_out_d;
            ctr_q   <= ctr_q + 4'd1;  // wraps to 0 on the 16th byte
            tcnt_q  <= '0;
            if (ctr_q == 4'd15) begin
              state_q <= ST_WRITE;
            end
          end else if (tcnt_q == TCNT_LAST) begin
            // Discard the partial frame. d_out keeps stale bytes, but nothing
            // downstream sees them because no write is issued.
            timeout_q <= 1'b1;
            ctr_q     <= 4'd0;
            tcnt_q    <= '0;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end

        ST_WRITE: begin
          // d_out is frozen here, including on the exit edge. A byte that
          // arrives now has nowhere to go.
          if (rx_done) begin
            overrun_q <= 1'b1;
          end
          if (!buffer_full) begin
            buffer_write_q <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= ST_IDLE;
          end
        end

        default: begin
          ctr_q   <= 4'd0;
          tcnt_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign buffer_write = buffer_write_q;
  assign d_out        = d_out_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_rx_assemble.sv
// Bench for rx_assemble. It runs directed scenarios followed by randomized
// traffic. Every cycle is checked against a frame-level reference model.

module tb_rx_assemble;

  localparam int unsigned T = 20;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   rx_data;
  logic         rx_done;
  logic         buffer_full;
  logic         buffer_write;
  logic [127:0] d_out;
  logic         busy;
  logic         overrun;
  logic         timeout;

  rx_assemble #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .buffer_full  (buffer_full),
    .buffer_write (buffer_write),
    .d_out        (d_out),
    .busy         (busy),
    .overrun      (overrun),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: a queue of bytes in the current frame, plus a finished
  // word waiting to be written.
  logic [7:0]   frame_q[$];
  logic         have_word = 1'b0;
  logic [127:0] word = '0;
  int           idle_cnt = 0;
  logic         exp_bw, exp_ov, exp_to, exp_busy;
  logic         in_reset = 1'b0;

  // Observed event bookkeeping for the directed checks.
  int           writes_seen   = 0;
  int           overruns_seen = 0;
  int           timeouts_seen = 0;
  logic [127:0] last_write    = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack_frame();
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      w[127 - 8*i -: 8] = frame_q[i];
    end
    return w;
  endfunction

  task automatic model_edge();
    exp_bw = 1'b0;
    exp_ov = 1'b0;
    exp_to = 1'b0;
    if (!reset) begin
      frame_q.delete();
      have_word = 1'b0;
      idle_cnt  = 0;
      in_reset  = 1'b1;
    end else begin
      in_reset = 1'b0;
      if (have_word) begin
        if (rx_done) exp_ov = 1'b1;
        if (!buffer_full) begin
          exp_bw    = 1'b1;
          have_word = 1'b0;
        end
      end else if (rx_done) begin
        frame_q.push_back(rx_data);
        idle_cnt = 0;
        if (frame_q.size() == 16) begin
          word      = pack_frame();
          have_word = 1'b1;
          frame_q.delete();
        end
      end else if (frame_q.size() > 0) begin
        idle_cnt++;
        if (idle_cnt == T) begin
          exp_to = 1'b1;
          frame_q.delete();
          idle_cnt = 0;
        end
      end
    end
    exp_busy = have_word || (frame_q.size() > 0);
  endtask

  task automatic check_outputs();
    chk("buffer_write", 128'(buffer_write), 128'(exp_bw));
    chk("overrun",      128'(overrun),      128'(exp_ov));
    chk("timeout",      128'(timeout),      128'(exp_to));
    chk("busy",         128'(busy),         128'(exp_busy));
    if (exp_bw)   chk("d_out_write", d_out, word);
    if (in_reset) chk("d_out_reset", d_out, 128'h0);
    if (buffer_write === 1'b1) begin
      writes_seen++;
      last_write = d_out;
    end
    if (overrun === 1'b1) overruns_seen++;
    if (timeout === 1'b1) timeouts_seen++;
    $display("t=%0t rst=%b rxd=%b data=%h full=%b | bw=%b ov=%b to=%b busy=%b",
             $time, reset, rx_done, rx_data, buffer_full, buffer_write, overrun, timeout, busy);
  endtask

  // One clock cycle: drive inputs, clock the DUT and the model, and check
  // the outputs on the falling edge.
  task automatic step(input logic d, input logic [7:0] b, input logic f, input logic r);
    rx_done     = d;
    rx_data     = b;
    buffer_full = f;
    reset       = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input logic f);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, f, 1'b1);
  endtask

  task automatic send_seq(input logic [7:0] first, input int n, input logic down, input logic full_last);
    for (int i = 0; i < n; i++) begin
      step(1'b1, down ? 8'(first - 8'(i)) : 8'(first + 8'(i)),
           (i == n - 1) ? full_last : 1'b0, 1'b1);
    end
  endtask

  int base_w, base_o, base_t, gap;
  logic full_r;

  initial begin
    rx_done = 1'b0; rx_data = 8'h00; buffer_full = 1'b0; reset = 1'b0;

    // Reset, then one clean frame.
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    idle(2, 1'b0);
    send_seq(8'h00, 16, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("t1_writes", 128'(writes_seen), 128'd1);
    chk("t1_dout", last_write, 128'h000102030405060708090A0B0C0D0E0F);
    chk("t1_events", 128'(overruns_seen + timeouts_seen), 128'd0);

    // Back-to-back frames.
    send_seq(8'h10, 16, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("t2_dout_a", last_write, 128'h101112131415161718191A1B1C1D1E1F);
    send_seq(8'hA0, 16, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("t2_writes", 128'(writes_seen), 128'd3);
    chk("t2_dout_b", last_write, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);

    // Buffer full for 50 cycles, with a byte injected during the wait.
    base_w = writes_seen; base_o = overruns_seen;
    send_seq(8'hFF, 16, 1'b1, 1'b1);
    idle(20, 1'b1);
    step(1'b1, 8'h55, 1'b1, 1'b1);
    idle(29, 1'b1);
    chk("t3_no_write_while_full", 128'(writes_seen - base_w), 128'd0);
    chk("t3_busy_waiting", 128'(busy), 128'd1);
    idle(3, 1'b0);
    chk("t3_writes", 128'(writes_seen - base_w), 128'd1);
    chk("t3_dout", last_write, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
    chk("t3_overruns", 128'(overruns_seen - base_o), 128'd1);
    send_seq(8'h60, 16, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("t4_dout", last_write, 128'h606162636465666768696A6B6C6D6E6F);

    // Inactivity timeout, then a clean frame.
    base_w = writes_seen; base_t = timeouts_seen;
    send_seq(8'hC0, 5, 1'b0, 1'b0);
    idle(T + 2, 1'b0);
    chk("t5_timeouts", 128'(timeouts_seen - base_t), 128'd1);
    chk("t5_no_write", 128'(writes_seen - base_w), 128'd0);
    chk("t5_busy", 128'(busy), 128'd0);
    send_seq(8'h20, 16, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("t5_dout", last_write, 128'h202122232425262728292A2B2C2D2E2F);

    // A byte arriving exactly on the expiry edge keeps the frame alive.
    base_t = timeouts_seen;
    send_seq(8'hB0, 3, 1'b0, 1'b0);
    idle(T - 1, 1'b0);
    send_seq(8'hB3, 13, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("t5b_no_timeout", 128'(timeouts_seen - base_t), 128'd0);
    chk("t5b_dout", last_write, 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF);

    // Reset in the middle of a frame.
    base_w = writes_seen;
    send_seq(8'h77, 10, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    send_seq(8'h30, 16, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("t6_writes", 128'(writes_seen - base_w), 128'd1);
    chk("t6_dout", last_write, 128'h303132333435363738393A3B3C3D3E3F);

    // Randomized traffic: mostly short gaps, occasional gaps near the
    // timeout boundary, random back-pressure and rare resets.
    for (int n = 0; n < 600; n++) begin
      gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(T - 2, T + 3))
                                        : int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        full_r = ($urandom_range(0, 3) == 0);
        step(1'b0, 8'($urandom), full_r, 1'b1);
      end
      full_r = ($urandom_range(0, 3) == 0);
      step(1'b1, 8'($urandom), full_r, ($urandom_range(0, 199) != 0));
    end
    idle(T + 5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
